main_memory_interface: RTL

MAIN_MEMORY_INTERFACE -- requirements
Module: main_memory_interface

---
 rtl/main_memory_interface.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/main_memory_interface.sv
// Line-granular bridge between an L2 cache and a single-port word SRAM.
// Reads and writes a whole line one word per cycle, then holds the response until released.
module main_memory_interface #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDRESS_BITS   = 32,
   parameter int MSG_BITS       = 4,
   parameter int OFFSET_BITS    = 2,
   parameter int MEM_INDEX_BITS = 10
) (
   input  logic                                      clock,
   input  logic                                      reset,
   input  logic [MSG_BITS-1:0]                       cache2mem_msg,
   input  logic [ADDRESS_BITS-1:0]                   cache2mem_address,
   input  logic [(1<<OFFSET_BITS)*DATA_WIDTH-1:0]    cache2mem_data,
   output logic [MSG_BITS-1:0]                       mem2cache_msg,
   output logic [ADDRESS_BITS-1:0]                   mem2cache_address,
   output logic [(1<<OFFSET_BITS)*DATA_WIDTH-1:0]    mem2cache_data,
   output logic [MEM_INDEX_BITS-1:0]                 mem_addr,
   output logic                                      mem_we,
   output logic [DATA_WIDTH-1:0]                     mem_wdata,
   input  logic [DATA_WIDTH-1:0]                     mem_rdata
);

   localparam int W      = 1 << OFFSET_BITS;
   localparam int LINE_W = W * DATA_WIDTH;

   localparam logic [MSG_BITS-1:0] NO_REQ      = MSG_BITS'(0);
   localparam logic [MSG_BITS-1:0] R_REQ       = MSG_BITS'(1);
   localparam logic [MSG_BITS-1:0] WB_REQ      = MSG_BITS'(2);
   localparam logic [MSG_BITS-1:0] FLUSH       = MSG_BITS'(3);
   localparam logic [MSG_BITS-1:0] MEM_NO_MSG  = MSG_BITS'(0);
   localparam logic [MSG_BITS-1:0] MEM_RESP    = MSG_BITS'(11);

   localparam logic [OFFSET_BITS:0] K_FULL    = (OFFSET_BITS+1)'(W);
   localparam logic [OFFSET_BITS:0] K_LAST_WR = (OFFSET_BITS+1)'(W-1);
   localparam logic [OFFSET_BITS:0] K_ONE     = (OFFSET_BITS+1)'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t                    r_state;
   state_t                    w_next;
   logic [OFFSET_BITS:0]      r_k;
   logic [ADDRESS_BITS-1:0]   r_base;
   logic [LINE_W-1:0]         r_line;

   logic                      w_is_rd;
   logic                      w_is_wr;
   logic [ADDRESS_BITS-1:0]   w_word_addr;
   logic [OFFSET_BITS-1:0]    w_cap_idx;
   logic [DATA_WIDTH-1:0]     w_wr_word;

   assign w_is_rd = (cache2mem_msg == R_REQ);
   assign w_is_wr = (cache2mem_msg == WB_REQ) || (cache2mem_msg == FLUSH);

   // Base has its offset bits cleared, so splicing k in place of them cannot carry into the tag.
   assign w_word_addr = {r_base[ADDRESS_BITS-1:OFFSET_BITS], r_k[OFFSET_BITS-1:0]};

   // SRAM data lags the address by one cycle, so the word arriving now belongs to k-1.
   assign w_cap_idx = r_k[OFFSET_BITS-1:0] - OFFSET_BITS'(1);

   always_comb begin
      w_wr_word = '0;
      for (int i = 0; i < W; i++) begin
         if (r_k[OFFSET_BITS-1:0] == OFFSET_BITS'(i)) begin
            w_wr_word = r_line[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next            = r_state;
      mem_we            = 1'b0;
      mem_addr          = '0;
      mem_wdata         = '0;
      mem2cache_msg     = MEM_NO_MSG;
      mem2cache_address = '0;
      mem2cache_data    = '0;
      case (r_state)
         S_IDLE: begin
            if (w_is_rd) begin
               w_next = S_READ;
            end else if (w_is_wr) begin
               w_next = S_WRITE;
            end
         end
         S_READ: begin
            if (r_k < K_FULL) begin
               mem_addr = w_word_addr[MEM_INDEX_BITS-1:0];
            end
            if (r_k == K_FULL) begin
               w_next = S_RESP;
            end
         end
         S_WRITE: begin
            mem_we    = 1'b1;
            mem_addr  = w_word_addr[MEM_INDEX_BITS-1:0];
            mem_wdata = w_wr_word;
            if (r_k == K_LAST_WR) begin
               w_next = S_RESP;
            end
         end
         S_RESP: begin
            mem2cache_msg     = MEM_RESP;
            mem2cache_address = r_base;
            mem2cache_data    = r_line;
            if (cache2mem_msg == NO_REQ) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_k    <= '0;
         r_base <= '0;
         r_line <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_is_rd || w_is_wr) begin
                  r_base <= {cache2mem_address[ADDRESS_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                  r_k    <= '0;
               end
               if (w_is_wr) begin
                  r_line <= cache2mem_data;
               end
            end
            S_READ: begin
               if (r_k != '0) begin
                  for (int i = 0; i < W; i++) begin
                     if (w_cap_idx == OFFSET_BITS'(i)) begin
                        r_line[i*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
                     end
                  end
               end
               if (r_k < K_FULL) begin
                  r_k <= r_k + K_ONE;
               end
            end
            S_WRITE: r_k <= r_k + K_ONE;
            default: ;
         endcase
      end
   end

endmodule
